// File: rtl/kianv_pkg.sv
// Shared kianv definitions: instruction-cache FSM encodings and prefetch queue entry layout.
package kianv_pkg;

  localparam int unsigned PF_DEPTH_DEFAULT = 4;
  localparam int unsigned PF_TAG_W         = 30;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_DISCARD = 2'd2
  } ic_state_e;

  // Word address tag plus the instruction fetched from it.
  typedef struct packed {
    logic [PF_TAG_W-1:0] addr;
    logic [31:0]         insn;
  } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch entry storage: power-of-two circular FIFO with single-cycle flush.
module prefetch_fifo
  import kianv_pkg::*;
#(
  parameter int unsigned DEPTH = PF_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  pf_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full_c,
  output logic                   empty_c,
  output pf_entry_t              head_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pf_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));
  assign head_c  = mem[rd_ptr];
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher between the CPU fetch port and the instruction cache.
module ifetch_prefetch
  import kianv_pkg::*;
#(
  parameter int unsigned DEPTH = PF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_valid_i,
  output logic [31:0] cpu_dout_o,
  output logic        cpu_ready_o,
  output logic [31:0] ic_addr_o,
  output logic        ic_valid_o,
  input  logic [31:0] ic_dout_i,
  input  logic        ic_ready_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  ic_state_e            state_q, state_d;
  logic [31:0]          pf_addr_q, pf_addr_d, ic_addr_d, cpu_dout_d;
  logic                 ic_valid_d, cpu_ready_d;
  logic                 full_c, empty_c, push_c, pop_c, qflush_c;
  pf_entry_t            head_c, push_data_c;
  logic [CNT_W-1:0]     count;
  logic [OCC_W-1:0]     occ_c;
  logic [PF_TAG_W-1:0]  cpu_tag_c, expect_tag_c;
  logic                 hit_c, redirect_c, gate_open_c, issue_c;
  logic                 unused_c;

  assign unused_c  = ^cpu_addr_i[1:0];
  assign cpu_tag_c = cpu_addr_i[31:2];

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .flush     (qflush_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .head_c    (head_c),
    .count     (count)
  );

  assign push_data_c = '{addr: ic_addr_o[31:2], insn: ic_dout_i};

  // Address the CPU is expected to ask for next if it follows the prefetch stream.
  always_comb begin
    if (!empty_c)                expect_tag_c = head_c.addr;
    else if (state_q == IC_REQ)  expect_tag_c = ic_addr_o[31:2];
    else                         expect_tag_c = pf_addr_q[31:2];
  end

  // The request slot in flight counts toward occupancy so a completing fetch always has room.
  assign occ_c       = OCC_W'(count) + OCC_W'(state_q == IC_REQ);
  assign hit_c       = cpu_valid_i && !cpu_ready_o && !empty_c && (head_c.addr == cpu_tag_c);
  assign redirect_c  = cpu_valid_i && !cpu_ready_o && (cpu_tag_c != expect_tag_c);
  // No speculative fetch across a 4 KiB page until the CPU itself asks for the new page.
  assign gate_open_c = (pf_addr_q[11:0] != 12'd0) ||
                       (empty_c && cpu_valid_i && (cpu_tag_c == pf_addr_q[31:2]));
  assign issue_c     = !full_c && (occ_c < OCC_W'(DEPTH)) && !flush_i && !redirect_c && gate_open_c;

  always_comb begin
    state_d     = state_q;
    pf_addr_d   = pf_addr_q;
    ic_addr_d   = ic_addr_o;
    cpu_ready_d = 1'b0;
    cpu_dout_d  = cpu_dout_o;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    qflush_c    = flush_i || redirect_c;

    if (hit_c && !flush_i) begin
      cpu_ready_d = 1'b1;
      cpu_dout_d  = head_c.insn;
      pop_c       = 1'b1;
    end
    if (redirect_c) pf_addr_d = {cpu_addr_i[31:2], 2'b00};

    case (state_q)
      IC_IDLE: begin
        if (issue_c) begin
          state_d   = IC_REQ;
          ic_addr_d = pf_addr_q;
        end
      end
      IC_REQ: begin
        // A response coinciding with a flush/redirect is simply dropped.
        if (ic_ready_i) begin
          state_d = IC_IDLE;
          if (!qflush_c) begin
            push_c    = 1'b1;
            pf_addr_d = pf_addr_q + 32'd4;
          end
        end else if (qflush_c) begin
          state_d = IC_DISCARD;
        end
      end
      IC_DISCARD: begin
        if (ic_ready_i) state_d = IC_IDLE;
      end
      default: state_d = IC_IDLE;
    endcase

    ic_valid_d = (state_d != IC_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IC_IDLE;
      pf_addr_q   <= '0;
      ic_addr_o   <= '0;
      ic_valid_o  <= 1'b0;
      cpu_ready_o <= 1'b0;
      cpu_dout_o  <= '0;
    end else begin
      state_q     <= state_d;
      pf_addr_q   <= pf_addr_d;
      ic_addr_o   <= ic_addr_d;
      ic_valid_o  <= ic_valid_d;
      cpu_ready_o <= cpu_ready_d;
      cpu_dout_o  <= cpu_dout_d;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch with an instruction-cache model and a CPU-side scoreboard.
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        resetn, flush_i, cpu_valid_i, ic_ready_i;
  logic [31:0] cpu_addr_i, cpu_dout_o, ic_addr_o, ic_dout_i;
  logic        cpu_ready_o, ic_valid_o;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  bit          hold = 1'b0;
  int          ic_wait = 0;
  int          ready_consec = 0;
  logic        ready_prev = 1'b0;
  logic        valid_prev = 1'b0;
  logic [31:0] ic_log [$];
  logic [31:0] exp_q  [$];

  ifetch_prefetch #(.DEPTH(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush_i     (flush_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_valid_i (cpu_valid_i),
    .cpu_dout_o  (cpu_dout_o),
    .cpu_ready_o (cpu_ready_o),
    .ic_addr_o   (ic_addr_o),
    .ic_valid_o  (ic_valid_o),
    .ic_dout_i   (ic_dout_i),
    .ic_ready_i  (ic_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < ic_log.size()) ? ic_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Instruction cache: answers a request after lat cycles unless held.
  initial begin
    ic_ready_i = 1'b0;
    ic_dout_i  = '0;
    forever begin
      @(posedge clk); #1;
      if (!resetn || ic_ready_i) begin
        ic_ready_i = 1'b0;
        ic_wait    = 0;
      end else if (ic_valid_o && !hold) begin
        ic_wait++;
        if (ic_wait >= lat) begin
          ic_ready_i = 1'b1;
          ic_dout_i  = mem_word(ic_addr_o);
        end
      end
    end
  end

  // Record every new icache request and any back-to-back cpu_ready_o.
  always @(negedge clk) begin
    if (ic_valid_o && !valid_prev) ic_log.push_back(ic_addr_o);
    if (cpu_ready_o && ready_prev) ready_consec++;
    valid_prev = ic_valid_o;
    ready_prev = cpu_ready_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    resetn = 1'b0; flush_i = 1'b0; cpu_valid_i = 1'b0; cpu_addr_i = '0;
    hold = 1'b0; lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    ic_log.delete();
    exp_q.delete();
    #1;
  endtask

  // Present one fetch, wait for completion (bounded), expected word goes to the scoreboard.
  task automatic cpu_fetch(input logic [31:0] a, output bit got, output logic [31:0] dout,
                           output int cyc);
    exp_q.push_back(mem_word(a));
    cpu_addr_i = a; cpu_valid_i = 1'b1; cyc = 0; got = 1'b0; dout = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      flush_i = 1'b0;
      cyc++;
      if (cpu_ready_o) begin got = 1'b1; dout = cpu_dout_o; end
    end
    cpu_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ic_valid_o !== 1'b0) begin errors++; $display("FAIL reset_ic_valid got=%b exp=0", ic_valid_o); end
    checks++; if (ic_addr_o !== 32'h0) begin errors++; $display("FAIL reset_ic_addr got=%h exp=0", ic_addr_o); end
    checks++; if (cpu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready_o); end
    checks++; if (cpu_dout_o !== 32'h0) begin errors++; $display("FAIL reset_cpu_dout got=%h exp=0", cpu_dout_o); end
    idle(6);
    checks++; if (ic_log.size() != 0) begin errors++; $display("FAIL reset_no_fetch got=%0d exp=0", ic_log.size()); end
  endtask

  task automatic test_sequential();
    bit got; logic [31:0] d, e; int cyc;
    do_reset();
    cpu_fetch(32'h0, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL seq_first got=%h exp=%h", d, e); end
    checks++; if (cyc != lat + 2) begin errors++; $display("FAIL seq_latency got=%0d exp=%0d", cyc, lat + 2); end
    idle(12);
    checks++; if (ic_log.size() != 5) begin errors++; $display("FAIL seq_fill got=%0d exp=5", ic_log.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_at(i) !== 32'(i * 4)) begin errors++; $display("FAIL seq_ic_addr%0d got=%h exp=%h", i, log_at(i), 32'(i * 4)); end
    end
    for (int k = 1; k <= 8; k++) begin
      cpu_fetch(32'(k * 4), got, d, cyc);
      e = exp_q.pop_front();
      checks++; if (!got || d !== e) begin errors++; $display("FAIL seq_word%0d got=%h exp=%h", k, d, e); end
      if (k == 1) begin
        checks++; if (cyc != 1) begin errors++; $display("FAIL seq_hit_latency got=%0d exp=1", cyc); end
      end
    end
  endtask

  task automatic test_redirect();
    bit got, seen; logic [31:0] d, e; int cyc;
    do_reset();
    lat = 4;
    cpu_fetch(32'hC, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL redir_first got=%h exp=%h", d, e); end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (ic_valid_o && ic_addr_o == 32'h18) seen = 1'b1;
    end
    hold = 1'b1;
    checks++; if (!seen) begin errors++; $display("FAIL redir_inflight got=none exp=00000018"); end
    exp_q.push_back(mem_word(32'h200));
    cpu_addr_i = 32'h200; cpu_valid_i = 1'b1;
    idle(3);
    checks++;
    if (ic_valid_o !== 1'b1 || ic_addr_o !== 32'h18) begin
      errors++; $display("FAIL redir_discard_hold got=%b/%h exp=1/00000018", ic_valid_o, ic_addr_o);
    end
    hold = 1'b0; lat = 1; got = 1'b0; d = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      if (cpu_ready_o) begin got = 1'b1; d = cpu_dout_o; end
    end
    cpu_valid_i = 1'b0;
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL redir_word got=%h exp=%h", d, e); end
    checks++; if (log_at(3) !== 32'h18) begin errors++; $display("FAIL redir_log3 got=%h exp=00000018", log_at(3)); end
    checks++; if (log_at(4) !== 32'h200) begin errors++; $display("FAIL redir_next_fetch got=%h exp=00000200", log_at(4)); end
    cpu_fetch(32'h204, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL redir_follow got=%h exp=%h", d, e); end
  endtask

  task automatic test_page_gate();
    bit got; logic [31:0] d, e; int cyc;
    do_reset();
    cpu_fetch(32'hFF0, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL page_first got=%h exp=%h", d, e); end
    idle(15);
    checks++; if (ic_log.size() != 4) begin errors++; $display("FAIL page_stop got=%0d exp=4", ic_log.size()); end
    checks++; if (log_at(3) !== 32'hFFC) begin errors++; $display("FAIL page_last got=%h exp=00000ffc", log_at(3)); end
    for (int k = 1; k <= 3; k++) begin
      cpu_fetch(32'hFF0 + 32'(k * 4), got, d, cyc);
      e = exp_q.pop_front();
      checks++; if (!got || d !== e) begin errors++; $display("FAIL page_word%0d got=%h exp=%h", k, d, e); end
    end
    idle(5);
    checks++; if (ic_log.size() != 4) begin errors++; $display("FAIL page_no_cross got=%0d exp=4", ic_log.size()); end
    cpu_fetch(32'h1000, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL page_cross_word got=%h exp=%h", d, e); end
    checks++; if (cyc != lat + 2) begin errors++; $display("FAIL page_cross_latency got=%0d exp=%0d", cyc, lat + 2); end
    checks++; if (log_at(4) !== 32'h1000) begin errors++; $display("FAIL page_cross_fetch got=%h exp=00001000", log_at(4)); end
  endtask

  task automatic test_flush_hit();
    bit got; logic [31:0] d, e; int cyc;
    do_reset();
    cpu_fetch(32'h3C, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL flush_first got=%h exp=%h", d, e); end
    idle(12);
    flush_i = 1'b1;
    cpu_fetch(32'h40, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (cyc == 1) begin errors++; $display("FAIL flush_suppress got=ready_next_cycle exp=no_ready"); end
    checks++; if (!got || d !== e) begin errors++; $display("FAIL flush_word got=%h exp=%h", d, e); end
    checks++; if (log_at(5) !== 32'h40) begin errors++; $display("FAIL flush_refetch got=%h exp=00000040", log_at(5)); end
  endtask

  task automatic test_reset_midreq();
    bit got; logic [31:0] d, e; int cyc;
    do_reset();
    lat = 3;
    cpu_fetch(32'h7C, got, d, cyc);
    hold = 1'b1;
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL rst_pre_word got=%h exp=%h", d, e); end
    checks++;
    if (ic_valid_o !== 1'b1 || ic_addr_o !== 32'h80) begin
      errors++; $display("FAIL rst_pre_req got=%b/%h exp=1/00000080", ic_valid_o, ic_addr_o);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({ic_valid_o, cpu_ready_o} !== 2'b00 || ic_addr_o !== 32'h0 || cpu_dout_o !== 32'h0) begin
      errors++; $display("FAIL rst_async got=%b%b/%h/%h exp=00/0/0", ic_valid_o, cpu_ready_o, ic_addr_o, cpu_dout_o);
    end
    do_reset();
    cpu_fetch(32'h0, got, d, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || d !== e) begin errors++; $display("FAIL rst_restart_word got=%h exp=%h", d, e); end
    checks++; if (log_at(0) !== 32'h0) begin errors++; $display("FAIL rst_restart_addr got=%h exp=0", log_at(0)); end
  endtask

  task automatic test_back_to_back();
    bit got; logic [31:0] d, e, a; int cyc;
    do_reset();
    a = 32'h100;
    for (int i = 0; i < 24; i++) begin
      lat = int'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 16383)) & 32'hFFFF_FFFC;
      cpu_fetch(a, got, d, cyc);
      e = exp_q.pop_front();
      checks++; if (!got || d !== e) begin errors++; $display("FAIL b2b_word addr=%h got=%h exp=%h", a, d, e); end
      a = a + 32'd4;
      idle(int'($urandom_range(0, 2)));
    end
    checks++; if (ready_consec != 0) begin errors++; $display("FAIL ready_consecutive got=%0d exp=0", ready_consec); end
  endtask

  initial begin
    resetn = 1'b0; flush_i = 1'b0; cpu_valid_i = 1'b0; cpu_addr_i = '0;
    test_reset();
    test_sequential();
    test_redirect();
    test_page_gate();
    test_flush_hit();
    test_reset_midreq();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of prefetch queue entries (power of two, >=2).
REQ-002 The block SHALL have port clk  input  1  the single clock, rising-edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush_i  input  1  one-cycle pulse that discards all prefetched instructions.
REQ-005 The block SHALL have port cpu_addr_i  input  32  CPU fetch address.
REQ-006 The block SHALL have port cpu_valid_i  input  1  CPU fetch request, held until cpu_ready_o.
REQ-007 The block SHALL have port cpu_dout_o  output  32  instruction word returned to the CPU.
REQ-008 The block SHALL have port cpu_ready_o  output  1  one-cycle completion pulse to the CPU.
REQ-009 The block SHALL have port ic_addr_o  output  32  fetch address to the instruction cache.
REQ-010 The block SHALL have port ic_valid_o  output  1  request to the instruction cache.
REQ-011 The block SHALL have port ic_dout_i  input  32  instruction word from the instruction cache.
REQ-012 The block SHALL have port ic_ready_i  input  1  one-cycle instruction cache completion pulse.

Function
REQ-013 The block SHALL hold up to DEPTH entries {addr[31:2], insn}, FIFO-ordered, plus a fetch pointer pf_addr; address comparisons SHALL use bits [31:2] only.
REQ-014 The instruction-cache FSM SHALL have states IC_IDLE, IC_REQ and IC_DISCARD; ic_valid_o SHALL be 1 in IC_REQ and IC_DISCARD only.
REQ-015 From IC_IDLE the FSM SHALL enter IC_REQ when occupancy < DEPTH, flush_i is 0, and the page gate (REQ-021) is open, latching ic_addr_o <= pf_addr.
REQ-016 ic_addr_o SHALL be stable from entering IC_REQ until ic_ready_i; on ic_ready_i in IC_REQ, the block SHALL push {ic_addr_o, ic_dout_i}, set pf_addr += 4 (32-bit wrap), and return to IC_IDLE; ic_valid_o SHALL be 0 for at least one cycle between requests.
REQ-017 The expected address SHALL be: the head entry address if the queue is non-empty; otherwise ic_addr_o if in IC_REQ; otherwise pf_addr.
REQ-018 Hit: when cpu_valid_i=1, cpu_ready_o=0, the queue is non-empty and the head address equals cpu_addr_i, the block SHALL pulse cpu_ready_o for exactly one cycle on the next cycle, with cpu_dout_o = head insn, and pop at that edge.
REQ-019 Wait: when the queue is empty and cpu_addr_i equals the expected address, the block SHALL wait without redirect; hit latency SHALL be icache latency + 2 cycles.
REQ-020 Redirect: when cpu_valid_i=1 and cpu_addr_i differs from the expected address, the block SHALL, in one cycle, clear the queue, set pf_addr <= {cpu_addr_i[31:2],2'b00}, and move IC_REQ to IC_DISCARD.
REQ-021 Page gate: prefetch SHALL NOT issue when pf_addr[11:0]==0 unless the queue is empty and cpu_valid_i=1 with cpu_addr_i equal to pf_addr (no speculative Sv32 page crossing).
REQ-022 IC_DISCARD SHALL keep ic_valid_o and ic_addr_o unchanged until ic_ready_i, then drop ic_dout_i (no push, pf_addr unchanged) and go to IC_IDLE; in-flight requests are never aborted.
REQ-023 flush_i SHALL clear the queue, move IC_REQ to IC_DISCARD, leave pf_addr unchanged, and suppress any cpu_ready_o due the following cycle; the request then refetches.
REQ-024 A simultaneous push and pop SHALL both take effect with occupancy unchanged; occupancy counts the in-flight IC_REQ slot, so a push never overflows.
REQ-025 cpu_ready_o SHALL NOT assert in two consecutive cycles.

Reset
REQ-026 On resetn=0, asynchronously: queue empty, FSM IC_IDLE, pf_addr=0, ic_addr_o=0, ic_valid_o=0, cpu_ready_o=0, cpu_dout_o=0.
REQ-027 Reset mid-request SHALL abandon the in-flight fetch with no discard phase, since the instruction cache shares resetn.

Structure
REQ-028 FSM state encodings and the DEPTH default SHALL live in the shared kianv package.
REQ-029 The entry storage SHALL be one sub-module, prefetch_fifo (push, pop, flush, full, empty, head outputs).

Verification
REQ-030 Sequential run: after reset, CPU at 0x0 with icache 1-cycle latency -> ic_addr_o 0x0, 0x4, 0x8, 0xC; CPU gets the matching words; the queue never exceeds 4 entries.
REQ-031 Redirect with in-flight fetch: queue {0x10,0x14}, ic_addr_o 0x18 pending, CPU requests 0x200 -> queue cleared, IC_DISCARD; data for 0x18 dropped; next ic_addr_o 0x200.
REQ-032 Page boundary: fetching from 0xFF0 -> prefetch stops after 0xFFC; no ic request for 0x1000 until the CPU requests 0x1000.
REQ-033 flush_i in the same cycle as a head hit at 0x40 -> no cpu_ready_o; 0x40 refetched from the instruction cache and returned afterwards.
REQ-034 resetn low while IC_REQ at 0x80 -> all outputs 0 immediately; after release, fetch restarts at 0x0.
